keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Parametrised matrix-keypad scanner: drives one-hot column strobes, samples synchronised row inputs, and debounces every key independently. Press events, and release events when configured, are queued in a small event FIFO. The FIFO is drained over a valid/ready handshake. It sits between the keypad pins and the application FSM, and generalises the fixed 4x4 scanner to any ROWS x COLS matrix with multi-key (n-key rollover) detection.

## Interface
- `ROWS`, 4: keypad rows, 1..8.
- `COLS`, 4: keypad columns, 1..8.
- `CLK_HZ`, 27_000_000: clock frequency.
- `SCAN_HZ`, 10_000: column step rate; `SCAN_DIV = CLK_HZ/SCAN_HZ`, must be >= ROWS+4.
- `DEBOUNCE_SCANS`, 4: consecutive identical frame samples needed to change a key's state, 1..15.
- `FIFO_DEPTH`, 4: event queue depth, power of two, >= 2.
- `clk` input 1: clock, rising edge.
- `reset` input 1: synchronous, active-high reset.
- `filas_raw` input ROWS: asynchronous row inputs, active-high; row r is bit ROWS-1-r.
- `columnas` output COLS: one-hot column drive; column c is bit COLS-1-c.
- `key_valid` output 1: FIFO not empty.
- `key_ready` input 1: consumer accepts the head event.
- `key_code` output $clog2(ROWS*COLS): head event key index, computed as r*COLS + c.
- `key_release` output 1: head event is a release (0 = press).
- `overflow` output 1: sticky; an event was dropped.

## Operation
- Rows pass through a 2-FF synchroniser before any use.
- Dwell counter runs 0..SCAN_DIV-1 per column and wraps.
- FSM states:
  - DWELL: counter < SCAN_DIV-1.
  - SAMPLE: counter == SCAN_DIV-1. Latch the synchronised rows, advance `columnas` (rotate right, bit 0 wraps to bit COLS-1), go to EVAL with r=0.
  - EVAL: one row per cycle for r = 0..ROWS-1, then DWELL. The dwell counter keeps running during EVAL.
- Per key state: 1-bit debounced state plus a 4-bit agreement counter.
- EVAL, key (r,c), where c is the column just sampled:
  - If the sample equals the debounced state, clear the counter.
  - Otherwise increment the counter. When the incremented value reaches DEBOUNCE_SCANS, toggle the state, clear the counter, and generate an event.
- Event push:
  - Pressed to released: push {release=1, code}.
  - Released to pressed: push {release=0, code}.
  - At most one push per cycle, guaranteed by serial EVAL.
- Several keys held simultaneously are tracked independently. A held key produces exactly one press event.
- FIFO behaviour:
  - Pop when `key_valid && key_ready`.
  - Push while full with no pop in the same cycle: drop the event and set `overflow`.
  - Push while full with a simultaneous pop: both happen, nothing is dropped.
  - Push while empty with `key_ready` high: the event appears on the next cycle; no bypass.
- `key_code`/`key_release` are held stable while `key_valid` is high and the event is not accepted. Their value is don't-care when `key_valid` is low.

## Timing
- Reset values:
  - `columnas` = one-hot with bit COLS-1 set.
  - Dwell counter = 0.
  - FSM in DWELL.
  - All keys released, all counters 0.
  - FIFO empty: `key_valid`=0, `key_code`=0, `key_release`=0, `overflow`=0.
- Reset during EVAL or with the FIFO non-empty discards all state; no release events are generated.
- Frame = COLS*SCAN_DIV cycles. Each key is sampled once per frame, on the last dwell cycle of its column.
- Press latency: the press is pushed DEBOUNCE_SCANS samples after the first stable sample of that key, plus r+1 cycles after its SAMPLE. `key_valid` rises one cycle after the push.
- Bounce shorter than one frame never changes state unless it aliases onto DEBOUNCE_SCANS consecutive samples.
- `overflow` clears only on `reset`.

## Configuration
- `KEYPAD_RELEASE_EVT_EN` defined: release transitions are pushed with `key_release`=1.
- Not defined: release transitions update the debounced state but push nothing; `key_release` is tied 0.

## Test plan
Bench parameters: ROWS=4, COLS=4, CLK_HZ=1000, SCAN_HZ=100 (SCAN_DIV=10), DEBOUNCE_SCANS=3, FIFO_DEPTH=4.
- Reset released -> `columnas` 4'b1000 for 10 cycles, then 0100, 0010, 0001, 1000; `key_valid`=0.
- Row 1 held high only while column 2 (4'b0010) is driven, `key_ready`=1 -> one event, code 6, `key_release`=0, about 3 frames after the hold starts; no further events while held.
- Same key (row 1, column 2) released with the macro defined -> one event, code 6, `key_release`=1; with the macro undefined -> no event.
- Row 0 bouncing every 7 cycles for 2 frames, then stable -> exactly one press event, code by column, after stabilisation.
- `key_ready`=0 with 5 distinct keys pressed -> 4 events queued, `overflow`=1. Then `key_ready`=1 -> codes pop in press order, `key_valid` low after the 4th pop.
- Keys 0 and 5 pressed, `reset` asserted mid-EVAL -> all outputs return to reset values. Keys still held after release of reset -> fresh press events for codes 0 and 5 after 3 frames.

Source files
------------

// File: rtl/keypad_scanner.sv
// ROWS x COLS keypad scanner: one-hot column drive, per-key debounce, event FIFO.
// Build option: define KEYPAD_RELEASE_EVT_EN to queue release events as well as presses.
module keypad_scanner #(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int CLK_HZ         = 27_000_000,
  parameter int SCAN_HZ        = 10_000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 4,
  localparam int NKEYS         = ROWS * COLS,
  localparam int KW            = (NKEYS > 1) ? $clog2(NKEYS) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [ROWS-1:0] filas_raw,
  output logic [COLS-1:0] columnas,
  output logic            key_valid,
  input  logic            key_ready,
  output logic [KW-1:0]   key_code,
  output logic            key_release,
  output logic            overflow,
  output logic [1:0]      scan_state
);

  localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int DW       = $clog2(SCAN_DIV);
  localparam int RW       = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW       = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int AW       = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_DWELL  = 2'd0,
    S_SAMPLE = 2'd1,
    S_EVAL   = 2'd2
  } state_t;

  // Handshake: an event transfers on a cycle where key_valid && key_ready;
  // key_code/key_release stay stable while key_valid is high and not accepted.

  state_t          state_q, state_d;
  logic [DW-1:0]   cnt_q, cnt_d;
  logic [COLS-1:0] col_q, col_d;
  logic [CW-1:0]   col_idx_q, col_idx_d;
  logic [CW-1:0]   eval_col_q, eval_col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [ROWS-1:0] sync1_q, sync2_q;
  logic [ROWS-1:0] smp_q, smp_d;
  logic [NKEYS-1:0] key_q, key_d;
  logic [3:0]      deb_q [NKEYS];
  logic [3:0]      deb_d [NKEYS];
  logic [KW-1:0]   mem_code_q [FIFO_DEPTH];
  logic [KW-1:0]   mem_code_d [FIFO_DEPTH];
`ifdef KEYPAD_RELEASE_EVT_EN
  logic [FIFO_DEPTH-1:0] mem_rel_q, mem_rel_d;
  logic            push_rel;
`endif
  logic [AW:0]     wr_q, wr_d, rd_q, rd_d;
  logic            ovf_q, ovf_d;

  logic [KW-1:0]   key_idx;
  logic            push;
  logic            pop;
  logic            full;

  assign key_idx = KW'(row_q) * KW'(COLS) + KW'(eval_col_q);

  // Scan sequencing: dwell counter, column rotation and the serial row walk.
  always_comb begin
    state_d    = state_q;
    cnt_d      = (cnt_q == DW'(SCAN_DIV - 1)) ? '0 : cnt_q + 1'b1;
    col_d      = col_q;
    col_idx_d  = col_idx_q;
    eval_col_d = eval_col_q;
    row_d      = row_q;
    smp_d      = smp_q;
    case (state_q)
      S_DWELL: begin
        if (cnt_q == DW'(SCAN_DIV - 2)) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        // Store rows in logical order so smp_q[r] is row r.
        for (int r = 0; r < ROWS; r++) smp_d[r] = sync2_q[ROWS-1-r];
        col_d      = (col_q >> 1) | (col_q << (COLS - 1));
        eval_col_d = col_idx_q;
        col_idx_d  = (col_idx_q == CW'(COLS - 1)) ? '0 : col_idx_q + 1'b1;
        row_d      = '0;
        state_d    = S_EVAL;
      end
      S_EVAL: begin
        if (row_q == RW'(ROWS - 1)) state_d = S_DWELL;
        else                        row_d   = row_q + 1'b1;
      end
      default: state_d = S_DWELL;
    endcase
  end

  // Debounce of the key addressed by the current EVAL row.
  always_comb begin
    key_d = key_q;
    for (int i = 0; i < NKEYS; i++) deb_d[i] = deb_q[i];
    push  = 1'b0;
`ifdef KEYPAD_RELEASE_EVT_EN
    push_rel = 1'b0;
`endif
    if (state_q == S_EVAL) begin
      if (smp_q[row_q] == key_q[key_idx]) begin
        deb_d[key_idx] = '0;
      end else if ((deb_q[key_idx] + 4'd1) == 4'(DEBOUNCE_SCANS)) begin
        key_d[key_idx] = ~key_q[key_idx];
        deb_d[key_idx] = '0;
`ifdef KEYPAD_RELEASE_EVT_EN
        push     = 1'b1;
        push_rel = key_q[key_idx];
`else
        push     = ~key_q[key_idx];
`endif
      end else begin
        deb_d[key_idx] = deb_q[key_idx] + 4'd1;
      end
    end
  end

  assign key_valid = (wr_q != rd_q);
  assign full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop       = key_valid && key_ready;

  // Event FIFO; a push into a full queue survives only if a pop frees the slot.
  always_comb begin
    for (int i = 0; i < FIFO_DEPTH; i++) mem_code_d[i] = mem_code_q[i];
`ifdef KEYPAD_RELEASE_EVT_EN
    mem_rel_d = mem_rel_q;
`endif
    wr_d  = wr_q;
    rd_d  = rd_q;
    ovf_d = ovf_q;
    if (pop) rd_d = rd_q + 1'b1;
    if (push) begin
      if (!full || pop) begin
        mem_code_d[wr_q[AW-1:0]] = key_idx;
`ifdef KEYPAD_RELEASE_EVT_EN
        mem_rel_d[wr_q[AW-1:0]] = push_rel;
`endif
        wr_d = wr_q + 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_DWELL;
      cnt_q      <= '0;
      col_q      <= COLS'(1) << (COLS - 1);
      col_idx_q  <= '0;
      eval_col_q <= '0;
      row_q      <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      smp_q      <= '0;
      key_q      <= '0;
      for (int i = 0; i < NKEYS; i++) deb_q[i] <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_code_q[i] <= '0;
`ifdef KEYPAD_RELEASE_EVT_EN
      mem_rel_q  <= '0;
`endif
      wr_q       <= '0;
      rd_q       <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      col_q      <= col_d;
      col_idx_q  <= col_idx_d;
      eval_col_q <= eval_col_d;
      row_q      <= row_d;
      sync1_q    <= filas_raw;
      sync2_q    <= sync1_q;
      smp_q      <= smp_d;
      key_q      <= key_d;
      for (int i = 0; i < NKEYS; i++) deb_q[i] <= deb_d[i];
      for (int i = 0; i < FIFO_DEPTH; i++) mem_code_q[i] <= mem_code_d[i];
`ifdef KEYPAD_RELEASE_EVT_EN
      mem_rel_q  <= mem_rel_d;
`endif
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      ovf_q      <= ovf_d;
    end
  end

  assign columnas   = col_q;
  assign key_code   = mem_code_q[rd_q[AW-1:0]];
`ifdef KEYPAD_RELEASE_EVT_EN
  assign key_release = mem_rel_q[rd_q[AW-1:0]];
`else
  assign key_release = 1'b0;
`endif
  assign overflow   = ovf_q;
  assign scan_state = state_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: reset vector table, directed multi-cycle sequences and
// randomized key activity checked against a frame-level keypad model.
`timescale 1ns/1ps
module tb_keypad_scanner;
  localparam int ROWS     = 4;
  localparam int COLS     = 4;
  localparam int CLK_HZ   = 1000;
  localparam int SCAN_HZ  = 100;
  localparam int DEB      = 3;
  localparam int DEPTH    = 4;
  localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int FRAME    = COLS * SCAN_DIV;
  localparam int NK       = ROWS * COLS;
  localparam int W        = 21;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [ROWS-1:0] filas_raw;
  logic [COLS-1:0] columnas;
  logic            key_valid;
  logic            key_ready = 1'b0;
  logic [3:0]      key_code;
  logic            key_release;
  logic            overflow;
  logic [1:0]      scan_state;

  logic [NK-1:0]   mat = '0;   // physically pressed keys, index r*COLS+c
  int              total = 0;
  int              bad = 0;
  int              tcyc = 0;   // cycles since the last reset release
  bit              rel_en;
  logic [W-1:0]    exp_q[$];
  logic [W-1:0]    got_q[$];
  int              m_state [NK];
  int              m_cnt [NK];
  logic            hold_v = 1'b0;
  logic [4:0]      hold_e = '0;

  typedef struct {
    int         cyc;
    logic [3:0] col;
    logic       valid;
  } vec_t;
  vec_t vtab [8];

  always #5 clk = ~clk;

  keypad_scanner #(
    .ROWS(ROWS), .COLS(COLS), .CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ),
    .DEBOUNCE_SCANS(DEB), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .filas_raw(filas_raw), .columnas(columnas),
    .key_valid(key_valid), .key_ready(key_ready), .key_code(key_code),
    .key_release(key_release), .overflow(overflow), .scan_state(scan_state)
  );

  // Keypad matrix: a pressed key connects its driven column to its row line.
  always_comb begin
    filas_raw = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (mat[r*COLS+c] && columnas[COLS-1-c] === 1'b1) filas_raw[ROWS-1-r] = 1'b1;
  end

  function automatic logic [W-1:0] pk(int cyc, bit rel, int code);
    pk = {16'(cyc), rel, 4'(code)};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, tcyc);
    end
  endtask

  // Accepted events are logged with the cycle on which they were first offered.
  always @(negedge clk) begin
    if (!reset && key_valid === 1'b1 && key_ready)
      got_q.push_back(pk(tcyc, key_release, int'(key_code)));
    if (hold_v && !reset)
      check("hold_stable", {key_valid, key_release, key_code}, {1'b1, hold_e});
    hold_v = !reset && key_valid === 1'b1 && !key_ready;
    hold_e = {key_release, key_code};
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      tcyc++;
    end
  endtask

  task automatic wait_until(int t);
    while (tcyc < t) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tcyc  = 0;
    got_q.delete();
    exp_q.delete();
    for (int k = 0; k < NK; k++) begin
      m_state[k] = 0;
      m_cnt[k]   = 0;
    end
  endtask

  // One frame of the keypad as the debouncer sees it: columns in drive order,
  // rows 0..ROWS-1 after each column sample, DEB agreeing samples flip a key.
  task automatic model_frame(int f);
    int k, s, smp_cyc;
    for (int c = 0; c < COLS; c++) begin
      smp_cyc = f*FRAME + c*SCAN_DIV + SCAN_DIV - 1;
      for (int r = 0; r < ROWS; r++) begin
        k = r*COLS + c;
        s = int'(mat[k]);
        if (s == m_state[k]) m_cnt[k] = 0;
        else begin
          m_cnt[k]++;
          if (m_cnt[k] == DEB) begin
            m_state[k] = s;
            m_cnt[k]   = 0;
            if (s == 1 || rel_en) exp_q.push_back(pk(smp_cyc + r + 2, s == 0, k));
          end
        end
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: run did not complete, got %0d expected 0 pending", tcyc);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int keys [5];
`ifdef KEYPAD_RELEASE_EVT_EN
    rel_en = 1'b1;
`else
    rel_en = 1'b0;
`endif
    vtab[0] = '{0,  4'b1000, 1'b0};
    vtab[1] = '{9,  4'b1000, 1'b0};
    vtab[2] = '{10, 4'b0100, 1'b0};
    vtab[3] = '{19, 4'b0100, 1'b0};
    vtab[4] = '{20, 4'b0010, 1'b0};
    vtab[5] = '{30, 4'b0001, 1'b0};
    vtab[6] = '{39, 4'b0001, 1'b0};
    vtab[7] = '{40, 4'b1000, 1'b0};

    // Reset state and column rotation.
    do_reset();
    check("rst_code", key_code, 0);
    check("rst_release", key_release, 0);
    check("rst_overflow", overflow, 0);
    for (int i = 0; i < 8; i++) begin
      wait_until(vtab[i].cyc);
      check("col_seq", columnas, vtab[i].col);
      check("col_valid", key_valid, vtab[i].valid);
    end

    // Single key (row 1, column 2): one press, then release.
    do_reset();
    key_ready = 1'b1;
    wait_until(4);
    mat[6] = 1'b1;
    wait_until(8*FRAME + 4);
    check("press6_cnt", got_q.size(), 1);
    if (got_q.size() >= 1) check("press6_evt", got_q[0], pk(112, 0, 6));
    mat[6] = 1'b0;
    wait_until(13*FRAME);
    check("rel6_cnt", got_q.size(), rel_en ? 2 : 1);
    if (rel_en && got_q.size() >= 2) check("rel6_evt", got_q[1], pk(432, 1, 6));

    // Key (row 0, column 1) bouncing every 7 cycles for two frames; both bounce
    // samples land low, so three stable samples start in frame 2.
    do_reset();
    key_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      wait_until(4 + 7*k);
      mat[1] = (k % 2 == 0);
    end
    wait_until(84);
    mat[1] = 1'b1;
    wait_until(7*FRAME);
    check("bounce_cnt", got_q.size(), 1);
    if (got_q.size() >= 1) check("bounce_evt", got_q[0], pk(181, 0, 1));
    mat = '0;

    // Five presses with the consumer stalled: four queue, the fifth is dropped.
    do_reset();
    key_ready = 1'b0;
    keys = '{3, 8, 9, 14, 2};
    for (int i = 0; i < 5; i++) begin
      wait_until(i*FRAME + 4);
      mat[keys[i]] = 1'b1;
    end
    wait_until(10*FRAME);
    check("ovf_valid", key_valid, 1);
    check("ovf_head", key_code, 3);
    check("ovf_flag", overflow, 1);
    key_ready = 1'b1;
    tick(8);
    check("ovf_pops", got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) check("ovf_order", got_q[i][4:0], {1'b0, 4'(keys[i])});
    check("ovf_drained", key_valid, 0);
    check("ovf_sticky", overflow, 1);
    mat = '0;

    // Reset in the middle of an EVAL walk with queued events.
    do_reset();
    key_ready = 1'b0;
    wait_until(4);
    mat[0] = 1'b1;
    mat[5] = 1'b1;
    wait_until(4*FRAME + 11);
    check("pre_rst_valid", key_valid, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_col", columnas, 4'b1000);
    check("mid_rst_valid", key_valid, 0);
    check("mid_rst_code", key_code, 0);
    check("mid_rst_ovf", overflow, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tcyc  = 0;
    got_q.delete();
    key_ready = 1'b1;
    wait_until(5*FRAME);
    check("rst_repress_cnt", got_q.size(), 2);
    if (got_q.size() >= 2) begin
      check("rst_repress0", got_q[0], pk(91, 0, 0));
      check("rst_repress5", got_q[1], pk(102, 0, 5));
    end
    mat = '0;

    // Random key activity, flipped at frame boundaries, against the frame model.
    do_reset();
    key_ready = 1'b1;
    for (int f = 0; f < 63; f++) begin
      wait_until(f*FRAME + 4);
      if (f < 60)
        for (int k = 0; k < NK; k++)
          if ($urandom_range(0, 5) == 0) mat[k] = ~mat[k];
      model_frame(f);
    end
    wait_until(64*FRAME);
    check("rand_cnt", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check("rand_evt", got_q[i], exp_q[i]);
    check("rand_ovf", overflow, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
